// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared definitions for the ALU command sequencer: the stage encoding
// shown on the front-panel LEDs and the default synchronizer and counter
// sizes used by every instance.
package alu_seq_pkg;

    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int DEFAULT_CNT_W       = 8;

    // Stage codes are what the display decodes, so the values are fixed.
    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        UPDATE  = 3'd3,
        SHOW    = 3'd4
    } state_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if
// Bundles the button inputs and the datapath strobes of the sequencer.
//   enter, undo      : debounced button levels, asynchronous to clk
//   load_A/B/Op      : one-cycle load strobes to the ALU register block
//   updateRes        : one-cycle result/flag capture strobe
//   stage            : current sequencer state code
//   ops_done         : completed-operation counter
// Modports: master = the sequencer, slave = front panel plus datapath.
//
// Strobe contract: every strobe is a registered single-cycle pulse with no
// back-pressure; the datapath must act on the cycle it sees it, and at most
// one strobe is high in any cycle.
interface alu_cmd_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             enter;
    logic             undo;
    logic             load_A;
    logic             load_B;
    logic             load_Op;
    logic             updateRes;
    logic [2:0]       stage;
    logic [CNT_W-1:0] ops_done;

    modport master (
        input  enter, undo,
        output load_A, load_B, load_Op, updateRes, stage, ops_done
    );

    modport slave (
        output enter, undo,
        input  load_A, load_B, load_Op, updateRes, stage, ops_done
    );
endinterface

// File: rtl/sync_edge_detect.sv
// sync_edge_detect
// Brings an asynchronous button level into the clk domain and emits a
// single-cycle pulse on each synchronized 0->1 transition.
//   clk, reset : clock and asynchronous active-low reset
//   din        : asynchronous level input
//   pulse      : one-cycle rising-edge event (combinational from flops)
// SYNC_STAGES must be at least 2.
module sync_edge_detect
    import alu_seq_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);
    logic [SYNC_STAGES-1:0] sync_q;
    // Fills with ones after reset release; its top bit marks the point at
    // which sync_q carries a genuine post-reset sample of din.
    logic [SYNC_STAGES-1:0] primed_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q   <= '0;
            primed_q <= '0;
            prev_q   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], din};
            primed_q <= {primed_q[SYNC_STAGES-2:0], 1'b1};
            // Until real samples arrive, pretend the button was already
            // held, so a press held across reset release never fires.
            prev_q   <= primed_q[SYNC_STAGES-1] ? sync_q[SYNC_STAGES-1] : 1'b1;
        end
    end

    assign pulse = primed_q[SYNC_STAGES-1] & sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Steps the ALU datapath through operand A, operand B, opcode and result
// capture from the enter/undo buttons, issuing single-cycle load strobes.
//   clk, reset : clock and asynchronous active-low reset
//   bus        : alu_cmd_sequencer_if master (buttons in; strobes, stage
//                and ops_done out, all registered)
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_cmd_sequencer_if.master  bus
);
    localparam logic [2:0] S_WAIT_A  = WAIT_A;
    localparam logic [2:0] S_WAIT_B  = WAIT_B;
    localparam logic [2:0] S_WAIT_OP = WAIT_OP;
    localparam logic [2:0] S_UPDATE  = UPDATE;
    localparam logic [2:0] S_SHOW    = SHOW;

    logic enter_ev;
    logic undo_ev;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_enter_sync (
        .clk   (clk),
        .reset (reset),
        .din   (bus.enter),
        .pulse (enter_ev)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_undo_sync (
        .clk   (clk),
        .reset (reset),
        .din   (bus.undo),
        .pulse (undo_ev)
    );

    logic [2:0]       state_q, state_d;
    // strobe bit order: {updateRes, load_Op, load_B, load_A}
    logic [3:0]       strobe_q, strobe_d;
    logic [CNT_W-1:0] ops_q;

    always_comb begin
        state_d  = state_q;
        strobe_d = 4'b0000;
        case (state_q)
            // undo is tested first everywhere: it wins over a same-cycle enter
            S_WAIT_A: begin
                if (!undo_ev && enter_ev) begin
                    state_d  = S_WAIT_B;
                    strobe_d = 4'b0001;
                end
            end
            S_WAIT_B: begin
                if (undo_ev) begin
                    state_d = S_WAIT_A;
                end else if (enter_ev) begin
                    state_d  = S_WAIT_OP;
                    strobe_d = 4'b0010;
                end
            end
            S_WAIT_OP: begin
                if (undo_ev) begin
                    state_d = S_WAIT_B;
                end else if (enter_ev) begin
                    state_d  = S_UPDATE;
                    strobe_d = 4'b0100;
                end
            end
            // Transient: the result register captures one cycle after the
            // opcode load so it sees the new opcode; button events are dropped.
            S_UPDATE: begin
                state_d  = S_SHOW;
                strobe_d = 4'b1000;
            end
            S_SHOW: begin
                if (undo_ev) begin
                    state_d = S_WAIT_OP;
                end else if (enter_ev) begin
                    state_d = S_WAIT_A;
                end
            end
            default: begin
                state_d = S_WAIT_A;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_WAIT_A;
            strobe_q <= 4'b0000;
            ops_q    <= '0;
        end else begin
            state_q  <= state_d;
            strobe_q <= strobe_d;
            if (strobe_d[3]) begin
                ops_q <= ops_q + CNT_W'(1);
            end
        end
    end

    assign bus.load_A    = strobe_q[0];
    assign bus.load_B    = strobe_q[1];
    assign bus.load_Op   = strobe_q[2];
    assign bus.updateRes = strobe_q[3];
    assign bus.stage     = state_q;
    assign bus.ops_done  = ops_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer
// Directed and randomized button activity against a cycle-level reference
// model built from the sequencer's published behaviour: rising-edge events
// delayed by the synchronizer depth, a stage transition table, and a counter.
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    localparam int S  = DEFAULT_SYNC_STAGES;
    localparam int CW = 8;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    alu_cmd_sequencer_if #(.CNT_W(CW)) bus ();

    alu_cmd_sequencer #(.SYNC_STAGES(S), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Stage reached on an accepted enter / undo event, indexed by stage code.
    int enter_next [5] = '{1, 2, 3, 3, 0};
    int undo_next  [5] = '{0, 0, 1, 3, 2};

    int   m_stage;
    int   m_strobe;      // -1 none, 0 load_A, 1 load_B, 2 load_Op, 3 updateRes
    int   m_ops;
    int   m_samples;     // clock edges seen since reset release
    logic m_prev_e, m_prev_u;
    bit   ev_e_q[$];     // events in flight through the synchronizer delay
    bit   ev_u_q[$];

    function automatic void model_reset();
        m_stage   = 0;
        m_strobe  = -1;
        m_ops     = 0;
        m_samples = 0;
        m_prev_e  = 1'b0;
        m_prev_u  = 1'b0;
        ev_e_q.delete();
        ev_u_q.delete();
        for (int i = 0; i < S; i++) begin
            ev_e_q.push_back(1'b0);
            ev_u_q.push_back(1'b0);
        end
    endfunction

    // A rise between two post-reset samples acts S edges later.
    function automatic void model_edge(input logic e, input logic u);
        bit re, ru, ee, ue;
        re = (m_samples >= 1) && e && !m_prev_e;
        ru = (m_samples >= 1) && u && !m_prev_u;
        m_prev_e = e;
        m_prev_u = u;
        m_samples++;
        ev_e_q.push_back(re);
        ev_u_q.push_back(ru);
        ee = ev_e_q.pop_front();
        ue = ev_u_q.pop_front();
        m_strobe = -1;
        if (m_stage == 3) begin
            m_stage  = 4;
            m_strobe = 3;
            m_ops    = (m_ops + 1) % (1 << CW);
        end else if (ue) begin
            m_stage = undo_next[m_stage];
        end else if (ee) begin
            if (m_stage < 3) m_strobe = m_stage;
            m_stage = enter_next[m_stage];
        end
    endfunction

    int la_count = 0;

    task automatic compare_all();
        logic [3:0] obs_str, exp_str;
        obs_str = {bus.updateRes, bus.load_Op, bus.load_B, bus.load_A};
        exp_str = (m_strobe < 0) ? 4'b0000 : 4'(1 << m_strobe);
        check_eq("stage", 32'(bus.stage), 32'(m_stage));
        check_eq("strobes", 32'(obs_str), 32'(exp_str));
        check_eq("ops_done", 32'(bus.ops_done), 32'(m_ops));
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle(input logic e, input logic u);
        bus.enter = e;
        bus.undo  = u;
        @(posedge clk);
        if (reset) model_edge(e, u);
        else       model_reset();
        @(negedge clk);
        compare_all();
        la_count += int'(bus.load_A);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0);
    endtask

    task automatic press_e(input int hold, input int gap);
        repeat (hold) cycle(1'b1, 1'b0);
        idle(gap);
    endtask

    task automatic press_u(input int hold, input int gap);
        repeat (hold) cycle(1'b0, 1'b1);
        idle(gap);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic full_seq();
        repeat (4) press_e(1, 3);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit found;
        int len;
        logic e, u;
        bus.enter = 1'b0;
        bus.undo  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        reset = 1'b1;

        // Basic walk: A, B, Op, result, spaced presses.
        idle(3);
        repeat (3) press_e(1, 10);
        check_eq("walk_stage", 32'(bus.stage), 32'd4);
        check_eq("walk_ops", 32'(bus.ops_done), 32'd1);

        // Long hold gives a single event.
        do_reset();
        idle(3);
        la_count = 0;
        repeat (50) cycle(1'b1, 1'b0);
        idle(5);
        check_eq("held_load_A_count", 32'(la_count), 32'd1);
        check_eq("held_stage", 32'(bus.stage), 32'd1);

        // Same-cycle enter and undo in WAIT_OP: undo wins.
        press_e(1, 6);
        cycle(1'b1, 1'b1);
        idle(6);
        check_eq("simul_stage", 32'(bus.stage), 32'd1);

        // Undo in WAIT_A, then undo/enter from SHOW.
        do_reset();
        idle(2);
        press_u(1, 4);
        press_u(2, 4);
        check_eq("undo_wait_a_stage", 32'(bus.stage), 32'd0);
        repeat (3) press_e(1, 5);
        press_u(1, 5);
        check_eq("show_undo_stage", 32'(bus.stage), 32'd2);
        press_e(1, 6);
        check_eq("redo_ops", 32'(bus.ops_done), 32'd2);

        // Counter wrap.
        do_reset();
        idle(2);
        repeat (255) full_seq();
        idle(4);
        check_eq("pre_wrap_ops", 32'(bus.ops_done), 32'd255);
        full_seq();
        idle(4);
        check_eq("wrap_ops", 32'(bus.ops_done), 32'd0);

        // Reset during UPDATE, then enter held across reset release.
        do_reset();
        idle(2);
        press_e(1, 4);
        press_e(1, 4);
        cycle(1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (bus.stage == 3'd3) found = 1'b1;
            else cycle(1'b0, 1'b0);
        end
        check_eq("reach_update", 32'(found), 32'd1);
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        check_eq("rst_update_stage", 32'(bus.stage), 32'd0);
        repeat (3) cycle(1'b1, 1'b0);
        reset = 1'b1;
        la_count = 0;
        repeat (20) cycle(1'b1, 1'b0);
        check_eq("held_release_load_A", 32'(la_count), 32'd0);
        idle(4);

        // Random button activity with occasional resets.
        repeat (150) begin
            e   = 1'($urandom_range(0, 1));
            u   = ($urandom_range(0, 3) == 0);
            len = $urandom_range(1, 6);
            repeat (len) cycle(e, u);
            if ($urandom_range(0, 49) == 0) do_reset();
        end
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
